// File: rtl/ram_param.sv
// Single-port parameterised RAM. After reset it runs a clear sweep (INIT), then serves reads and writes (RUN).
// Define RAM_PARITY_EN to store an even-parity bit per word and add the par_err output.
module ram_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              ready
`ifdef RAM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   counter;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                accept_wr;
    logic                accept_rd;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   rd_word;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        accept_wr = ready & wr;
        accept_rd = ready & rd;
`ifdef RAM_PARITY_EN
        wr_word   = {^data, data};
`else
        wr_word   = data;
`endif
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = wr_word;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = counter;
            mem_wdata = '0;
        end else if (accept_wr) begin
            mem_we    = 1'b1;
        end
        // rd and wr share one address, so a simultaneous write is returned directly (write-first).
        rd_word = accept_wr ? wr_word : mem[address];
    end

    // NOTE: the storage array has no reset; the INIT sweep defines its contents instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            counter   <= '0;
            ready     <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
`ifdef RAM_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            case (state)
                INIT: begin
                    counter <= counter + 1'b1;
                    if (counter == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase

            out_valid <= accept_rd;
            if (accept_rd) begin
                out <= rd_word[DATA_W-1:0];
            end
`ifdef RAM_PARITY_EN
            // A correctly stored word has even overall parity including its parity bit.
            par_err <= accept_rd & (^rd_word);
`endif
        end
    end

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: vector table, reset/parity sequences and randomized traffic
// against a behavioural model. Works with or without RAM_PARITY_EN.
module tb_ram_param;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              ready;
`ifdef RAM_PARITY_EN
    logic              par_err;
`endif

    ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr),
        .rd        (rd),
        .address   (address),
        .data      (data),
        .out       (out),
        .out_valid (out_valid),
        .ready     (ready)
`ifdef RAM_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: cycles since reset release, memory image, last read result.
    int model_edges;
    int model_mem [DEPTH];
    int model_out;
    int model_valid;

    typedef struct {
        logic r;
        logic w;
        int   a;
        int   d;
        int   exp_out;
        int   exp_valid;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Applies one cycle of stimulus, advances the model and compares all outputs.
    task automatic cyc(input logic r, input logic w, input int a, input int d);
        bit accepted;
        rd      = r;
        wr      = w;
        address = ADDR_W'(a);
        data    = DATA_W'(d);
        accepted = (model_edges >= DEPTH);
        @(posedge clk);
        #1;
        model_valid = 0;
        if (accepted) begin
            if (w) model_mem[a] = d;
            if (r) begin
                model_out   = model_mem[a];
                model_valid = 1;
            end
        end
        model_edges++;
        if (model_edges == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        end
        check("model_ready", 32'(ready), 32'(model_edges >= DEPTH));
        check("model_out", 32'(out), 32'(model_out));
        check("model_valid", 32'(out_valid), 32'(model_valid));
`ifdef RAM_PARITY_EN
        check("model_par_err", 32'(par_err), 32'd0);
`endif
    endtask

    // Asserts reset one step after an edge, checks the immediate clearing, releases between edges.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
`ifdef RAM_PARITY_EN
        check("rst_par_err", 32'(par_err), 32'd0);
`endif
        repeat (hold) @(posedge clk);
        #2;
        rst_n       = 1'b1;
        model_edges = 0;
        model_out   = 0;
        model_valid = 0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        address = '0;
        data    = '0;
        model_edges = 0;
        model_out   = 0;
        model_valid = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;

        // Vector table: reads of cleared memory, fill k->k, read back, write-first and read/write mix.
        for (int k = 0; k < DEPTH; k++) vq.push_back('{1'b1, 1'b0, k, 0, 0, 1});
        for (int k = 0; k < DEPTH; k++) vq.push_back('{1'b0, 1'b1, k, k, 0, 0});
        for (int k = 0; k < DEPTH; k++) vq.push_back('{1'b1, 1'b0, k, 0, k, 1});
        vq.push_back('{1'b1, 1'b1, 3, 9, 9, 1});
        vq.push_back('{1'b1, 1'b0, 3, 0, 9, 1});
        vq.push_back('{1'b1, 1'b0, 2, 0, 2, 1});
        vq.push_back('{1'b0, 1'b1, 5, 12, 2, 0});
        vq.push_back('{1'b1, 1'b0, 5, 0, 12, 1});
        vq.push_back('{1'b0, 1'b0, 0, 0, 12, 0});

        @(posedge clk);
        #1;
        do_reset(2);

        // Clear sweep: ready low for DEPTH cycles, high on the next.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, i, 15);
        check("init_done_ready", 32'(ready), 32'd1);

        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].w, vq[i].a, vq[i].d);
            check("vec_out", 32'(out), 32'(vq[i].exp_out));
            check("vec_valid", 32'(out_valid), 32'(vq[i].exp_valid));
        end

        // Reset in the middle of a second sweep restarts the whole sweep.
        for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, k, 15);
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0);
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b0, 0, 0);
            check("resweep_ready", 32'(ready), 32'(i == DEPTH - 1));
        end
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b1, 1'b0, k, 0);
            check("resweep_read", 32'(out), 32'd0);
        end

        // Every data value written and read back; parity must never flag.
        for (int v = 0; v < (1 << DATA_W); v++) begin
            cyc(1'b0, 1'b1, v % DEPTH, v);
            cyc(1'b1, 1'b0, v % DEPTH, 0);
            check("allval_out", 32'(out), 32'(v));
        end

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(1);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, (1 << DATA_W) - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
